// File: rtl/axist_avmm_rd_seq.sv
// AVMM read sequencer for the AXI-stream checker channels.
// For each channel in turn: poll the status register until its done bit is
// set, latch the pass / alignment verdict, then read a DATA_WORDS-word data
// snapshot. One read outstanding at a time.
// Optional build macro AXIST_RDSEQ_TIMEOUT_EN: give up on a channel after
// POLL_MAX not-done polls and flag o_timeout; without it polling never ends.
module axist_avmm_rd_seq #(
    parameter int unsigned NUM_CHNL   = 2,
    parameter int unsigned DATA_WORDS = 8,
    parameter int unsigned POLL_GAP   = 20,
    parameter int unsigned POLL_MAX   = 1024
) (
    input  logic                             avmm_clk,
    input  logic                             avmm_rst_n,
    input  logic                             i_start,
    input  logic [32*NUM_CHNL-1:0]           i_sts_addr,
    input  logic [32*NUM_CHNL-1:0]           i_dat_addr,
    output logic [31:0]                      o_address,
    output logic                             o_read,
    input  logic                             i_waitrequest,
    input  logic                             i_readdatavalid,
    input  logic [31:0]                      i_readdata,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [NUM_CHNL-1:0]              o_pass,
    output logic [NUM_CHNL-1:0]              o_err_align,
    output logic [NUM_CHNL-1:0]              o_timeout,
    output logic [32*DATA_WORDS*NUM_CHNL-1:0] o_snap
);

    localparam int unsigned CW = $clog2(NUM_CHNL + 1);
    localparam int unsigned WW = $clog2(DATA_WORDS + 1);
    localparam int unsigned GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CHNL - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(DATA_WORDS - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        StIdle, StPollRd, StPollWait, StGap, StDataRd, StDataWait, StNextCh, StDone
    } state_t;

    state_t        state;
    logic [CW-1:0] chan;
    logic [CW-1:0] chan_nxt;
    logic [WW-1:0] word;
    logic [WW-1:0] word_nxt;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   cur_sts;
    logic [31:0]   nxt_sts;
    logic [31:0]   cur_dat;
    logic [31:0]   word_addr;

`ifdef AXIST_RDSEQ_TIMEOUT_EN
    localparam int unsigned PW = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] LAST_POLL = PW'(POLL_MAX - 1);
    logic [PW-1:0] poll_cnt;
`else
    assign o_timeout = '0;
`endif

    // Per-channel address selection and next data-word address (wraps mod 2^32).
    always_comb begin
        cur_sts  = '0;
        nxt_sts  = '0;
        cur_dat  = '0;
        chan_nxt = chan + 1'b1;
        word_nxt = word + 1'b1;
        for (int unsigned c = 0; c < NUM_CHNL; c++) begin
            if (chan == CW'(c)) begin
                cur_sts = i_sts_addr[32*c +: 32];
                cur_dat = i_dat_addr[32*c +: 32];
            end
            if (chan_nxt == CW'(c)) begin
                nxt_sts = i_sts_addr[32*c +: 32];
            end
        end
        word_addr = cur_dat + (32'(word_nxt) << 2);
    end

    // Sequencer FSM with registered bus outputs and verdicts.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            state       <= StIdle;
            chan        <= '0;
            word        <= '0;
            gap_cnt     <= '0;
            o_read      <= 1'b0;
            o_address   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= '0;
            o_err_align <= '0;
            o_snap      <= '0;
`ifdef AXIST_RDSEQ_TIMEOUT_EN
            poll_cnt    <= '0;
            o_timeout   <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Stray readdatavalid (read abandoned by reset) is ignored here.
                    if (i_start) begin
                        chan        <= '0;
                        word        <= '0;
                        gap_cnt     <= '0;
                        o_pass      <= '0;
                        o_err_align <= '0;
                        o_snap      <= '0;
`ifdef AXIST_RDSEQ_TIMEOUT_EN
                        poll_cnt    <= '0;
                        o_timeout   <= '0;
`endif
                        o_read      <= 1'b1;
                        o_address   <= i_sts_addr[31:0];
                        o_busy      <= 1'b1;
                        state       <= StPollRd;
                    end
                end
                StPollRd: begin
                    if (!i_waitrequest) begin
                        o_read <= 1'b0;
                        state  <= StPollWait;
                    end
                end
                StPollWait: begin
                    if (i_readdatavalid) begin
                        if (i_readdata[3]) begin
                            for (int unsigned c = 0; c < NUM_CHNL; c++) begin
                                if (chan == CW'(c)) begin
                                    o_pass[c]      <= i_readdata[1] & i_readdata[0];
                                    o_err_align[c] <= ~i_readdata[1];
                                end
                            end
                            word      <= '0;
                            o_read    <= 1'b1;
                            o_address <= cur_dat;
                            state     <= StDataRd;
                        end else
`ifdef AXIST_RDSEQ_TIMEOUT_EN
                        if (poll_cnt == LAST_POLL) begin
                            for (int unsigned c = 0; c < NUM_CHNL; c++) begin
                                if (chan == CW'(c)) begin
                                    o_timeout[c] <= 1'b1;
                                end
                            end
                            state <= StNextCh;
                        end else
`endif
                        begin
`ifdef AXIST_RDSEQ_TIMEOUT_EN
                            poll_cnt <= poll_cnt + 1'b1;
`endif
                            if (POLL_GAP == 0) begin
                                o_read    <= 1'b1;
                                o_address <= cur_sts;
                                state     <= StPollRd;
                            end else begin
                                gap_cnt <= '0;
                                state   <= StGap;
                            end
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt == LAST_GAP) begin
                        o_read    <= 1'b1;
                        o_address <= cur_sts;
                        state     <= StPollRd;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                StDataRd: begin
                    if (!i_waitrequest) begin
                        o_read <= 1'b0;
                        state  <= StDataWait;
                    end
                end
                StDataWait: begin
                    if (i_readdatavalid) begin
                        for (int unsigned c = 0; c < NUM_CHNL; c++) begin
                            for (int unsigned w = 0; w < DATA_WORDS; w++) begin
                                if (chan == CW'(c) && word == WW'(w)) begin
                                    o_snap[32*(c*DATA_WORDS+w) +: 32] <= i_readdata;
                                end
                            end
                        end
                        if (word == LAST_WORD) begin
                            state <= StNextCh;
                        end else begin
                            word      <= word_nxt;
                            o_read    <= 1'b1;
                            o_address <= word_addr;
                            state     <= StDataRd;
                        end
                    end
                end
                StNextCh: begin
                    if (chan == LAST_CH) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= StDone;
                    end else begin
                        chan      <= chan_nxt;
`ifdef AXIST_RDSEQ_TIMEOUT_EN
                        poll_cnt  <= '0;
`endif
                        o_read    <= 1'b1;
                        o_address <= nxt_sts;
                        state     <= StPollRd;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axist_avmm_rd_seq.sv
// Bench for axist_avmm_rd_seq: a behavioural AVMM slave answers reads from
// per-channel status sequences and data tables; expected verdicts, snapshots
// and read counts come from a model of the polling rules.
`timescale 1ns/1ps
module tb_axist_avmm_rd_seq;

    localparam int unsigned NCH  = 2;
    localparam int unsigned DW   = 8;
    localparam int unsigned GAPC = 6;
    localparam int unsigned PMAX = 4;
    localparam int SW     = 32 * DW * NCH;
    localparam int BUDGET = 20000;
`ifdef AXIST_RDSEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              avmm_clk = 1'b0;
    logic              avmm_rst_n;
    logic              i_start;
    logic [32*NCH-1:0] i_sts_addr;
    logic [32*NCH-1:0] i_dat_addr;
    logic [31:0]       o_address;
    logic              o_read;
    logic              i_waitrequest;
    logic              i_readdatavalid;
    logic [31:0]       i_readdata;
    logic              o_busy;
    logic              o_done;
    logic [NCH-1:0]    o_pass;
    logic [NCH-1:0]    o_err_align;
    logic [NCH-1:0]    o_timeout;
    logic [SW-1:0]     o_snap;

    axist_avmm_rd_seq #(
        .NUM_CHNL  (NCH),
        .DATA_WORDS(DW),
        .POLL_GAP  (GAPC),
        .POLL_MAX  (PMAX)
    ) dut (
        .avmm_clk       (avmm_clk),
        .avmm_rst_n     (avmm_rst_n),
        .i_start        (i_start),
        .i_sts_addr     (i_sts_addr),
        .i_dat_addr     (i_dat_addr),
        .o_address      (o_address),
        .o_read         (o_read),
        .i_waitrequest  (i_waitrequest),
        .i_readdatavalid(i_readdatavalid),
        .i_readdata     (i_readdata),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_pass         (o_pass),
        .o_err_align    (o_err_align),
        .o_timeout      (o_timeout),
        .o_snap         (o_snap)
    );

    always #5 avmm_clk = ~avmm_clk;

    int cyc = 0;
    always @(posedge avmm_clk) cyc <= cyc + 1;

    // Stimulus configuration
    logic [31:0] sts_a   [NCH];
    logic [31:0] dat_a   [NCH];
    logic [31:0] sts_seq [NCH][16];
    int          sts_len [NCH];
    int          sts_idx [NCH];
    logic [31:0] dmem    [NCH][DW];
    int          wr_max;
    bit          wr_rand;
    bit          stray_valid;

    // Observations by the slave
    int sts_reads[NCH];
    int dat_reads[NCH];
    int min_sp   [NCH];
    int last_iss [NCH];
    int proto_err;
    int busy_err;

    // Model expectations
    logic [NCH-1:0] e_pass, e_align, e_to;
    logic [SW-1:0]  e_snap;
    int             e_polls [NCH];
    int             e_dreads[NCH];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic classify(input logic [31:0] a, output int kind, output int ch, output int k);
        kind = 0; ch = 0; k = 0;
        for (int c = 0; c < NCH; c++) begin
            if (a == sts_a[c]) begin kind = 1; ch = c; end
            for (int w = 0; w < DW; w++)
                if (a == dat_a[c] + 32'(4 * w)) begin kind = 2; ch = c; k = w; end
        end
    endtask

    task automatic note_issue(input logic [31:0] a);
        int kind, ch, k;
        classify(a, kind, ch, k);
        if (kind == 1) begin
            sts_reads[ch]++;
            if (last_iss[ch] >= 0 && cyc - last_iss[ch] < min_sp[ch]) min_sp[ch] = cyc - last_iss[ch];
            last_iss[ch] = cyc;
        end else if (kind == 2) begin
            dat_reads[ch]++;
        end else begin
            proto_err++;
        end
    endtask

    task automatic respond(input logic [31:0] a, output logic [31:0] d);
        int kind, ch, k;
        classify(a, kind, ch, k);
        d = $urandom;
        if (kind == 1) begin
            d = sts_seq[ch][sts_idx[ch]];
            if (sts_idx[ch] < sts_len[ch] - 1) sts_idx[ch]++;
        end else if (kind == 2) begin
            d = dmem[ch][k];
        end
    endtask

    // AVMM slave: stalls each read for a chosen number of cycles, then
    // answers after 0..2 idle cycles; flags protocol violations.
    initial begin : slave
        bit          req_active = 0;
        bit          pending = 0;
        int          wait_left = 0;
        int          resp_delay = 0;
        logic [31:0] req_addr = '0;
        logic [31:0] resp_data = '0;
        i_waitrequest = 1'b0;
        i_readdatavalid = 1'b0;
        i_readdata = '0;
        forever begin
            @(negedge avmm_clk);
            if (!avmm_rst_n) begin
                req_active = 0; pending = 0;
                i_waitrequest = 1'b0; i_readdatavalid = 1'b0;
                continue;
            end
            if (o_read && pending) proto_err++;
            if (req_active && !o_read) proto_err++;
            i_readdatavalid = 1'b0;
            i_readdata = $urandom;
            if (stray_valid) begin
                i_readdatavalid = 1'b1;
                stray_valid = 0;
            end else if (pending) begin
                if (resp_delay == 0) begin
                    i_readdatavalid = 1'b1;
                    i_readdata = resp_data;
                    pending = 0;
                end else begin
                    resp_delay--;
                end
            end
            if (o_read) begin
                if (!req_active) begin
                    req_active = 1;
                    req_addr = o_address;
                    wait_left = wr_rand ? int'($urandom_range(0, wr_max)) : wr_max;
                    note_issue(o_address);
                end else if (o_address !== req_addr) begin
                    proto_err++;
                end
                if (wait_left > 0) begin
                    i_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    i_waitrequest = 1'b0;
                    req_active = 0;
                    pending = 1;
                    resp_delay = $urandom_range(0, 2);
                    respond(req_addr, resp_data);
                end
            end else begin
                i_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic set_addrs();
        for (int c = 0; c < NCH; c++)
            sts_a[c] = 32'h4000_0000 + 32'(c) * 32'h0010_0000 + 32'($urandom_range(0, 255) << 2);
        dat_a[0] = 32'h8000_0000 + 32'($urandom_range(0, 1023) << 2);
        dat_a[1] = 32'hFFFF_FFF0;
        for (int c = 0; c < NCH; c++) begin
            i_sts_addr[32*c +: 32] = sts_a[c];
            i_dat_addr[32*c +: 32] = dat_a[c];
        end
    endtask

    task automatic data_index();
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < DW; w++) dmem[c][w] = 32'(w);
    endtask

    task automatic sts_single(input logic [31:0] s0, input logic [31:0] s1);
        sts_seq[0][0] = s0; sts_len[0] = 1;
        sts_seq[1][0] = s1; sts_len[1] = 1;
    endtask

    // Walk each channel's status sequence by the polling rules.
    task automatic compute_model();
        int lim;
        e_pass = '0; e_align = '0; e_to = '0; e_snap = '0;
        lim = TO_EN ? int'(PMAX) : 64;
        for (int c = 0; c < NCH; c++) begin
            int found = -1;
            logic [31:0] v = '0;
            for (int p = 0; p < lim && found < 0; p++) begin
                v = sts_seq[c][(p < sts_len[c]) ? p : sts_len[c] - 1];
                if (v[3]) found = p;
            end
            if (found >= 0) begin
                e_polls[c]  = found + 1;
                e_pass[c]   = v[1] & v[0];
                e_align[c]  = ~v[1];
                e_dreads[c] = DW;
                for (int w = 0; w < DW; w++) e_snap[32*(c*DW+w) +: 32] = dmem[c][w];
            end else begin
                e_polls[c]  = lim;
                e_to[c]     = 1'b1;
                e_dreads[c] = 0;
            end
        end
    endtask

    task automatic clear_obs();
        proto_err = 0; busy_err = 0;
        for (int c = 0; c < NCH; c++) begin
            sts_reads[c] = 0; dat_reads[c] = 0; sts_idx[c] = 0;
            min_sp[c] = 1000000; last_iss[c] = -1;
        end
    endtask

    task automatic run_seq(input string name);
        int  t = 0;
        int  dpulses = 0;
        bit  seen = 0;
        clear_obs();
        compute_model();
        @(negedge avmm_clk) i_start = 1'b1;
        @(negedge avmm_clk) i_start = 1'b0;
        while (!seen && t < BUDGET) begin
            @(negedge avmm_clk);
            t++;
            i_start = (t == 25);
            if (o_done) begin
                seen = 1; dpulses++;
                if (o_busy) busy_err++;
            end else if (!o_busy) begin
                busy_err++;
            end
        end
        i_start = 1'b0;
        check({name, " done_seen"}, SW'(seen), SW'(1));
        repeat (4) begin
            @(negedge avmm_clk);
            if (o_done) dpulses++;
            if (o_busy) busy_err++;
        end
        check({name, " done_pulses"}, SW'(dpulses), SW'(1));
        check({name, " busy_err"}, SW'(busy_err), SW'(0));
        check({name, " proto_err"}, SW'(proto_err), SW'(0));
        check({name, " pass"}, SW'(o_pass), SW'(e_pass));
        check({name, " err_align"}, SW'(o_err_align), SW'(e_align));
        check({name, " timeout"}, SW'(o_timeout), SW'(e_to));
        check({name, " snap"}, o_snap, e_snap);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("%s sts_reads[%0d]", name, c), SW'(sts_reads[c]), SW'(e_polls[c]));
            check($sformatf("%s dat_reads[%0d]", name, c), SW'(dat_reads[c]), SW'(e_dreads[c]));
            if (e_polls[c] > 1)
                check($sformatf("%s spacing_ok[%0d]", name, c),
                      SW'(min_sp[c] >= int'(GAPC) + 2), SW'(1));
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " read"}, SW'(o_read), SW'(0));
        check({name, " address"}, SW'(o_address), SW'(0));
        check({name, " busy"}, SW'(o_busy), SW'(0));
        check({name, " done"}, SW'(o_done), SW'(0));
        check({name, " pass"}, SW'(o_pass), SW'(0));
        check({name, " err_align"}, SW'(o_err_align), SW'(0));
        check({name, " timeout"}, SW'(o_timeout), SW'(0));
        check({name, " snap"}, o_snap, SW'(0));
    endtask

    initial begin : main
        int t;
        avmm_rst_n = 1'b0;
        i_start = 1'b0;
        wr_max = 0; wr_rand = 0; stray_valid = 0;
        clear_obs();
        set_addrs();
        data_index();
        sts_single(32'h0B, 32'h0B);
        repeat (3) @(negedge avmm_clk);
        #1 check_all_zero("reset");
        @(negedge avmm_clk) avmm_rst_n = 1'b1;

        // Both channels done on the first poll, data = word index
        run_seq("basic");
        check("basic pass_11", SW'(o_pass), SW'(2'b11));
        check("basic snap_w0", SW'(o_snap[31:0]), SW'(0));
        check("basic snap_w7", SW'(o_snap[255:224]), SW'(7));

        // Channel 0 not done three times, then done
        sts_seq[0][0] = 32'h03; sts_seq[0][1] = 32'h03; sts_seq[0][2] = 32'h03;
        sts_seq[0][3] = 32'h0B; sts_len[0] = 4;
        sts_seq[1][0] = 32'h0B; sts_len[1] = 1;
        run_seq("gap");
        check("gap ch0_polls_4", SW'(sts_reads[0]), SW'(4));

        // Channel 1 done with bad alignment: data still read
        sts_single(32'h0B, 32'h09);
        run_seq("align");
        check("align pass_01", SW'(o_pass), SW'(2'b01));
        check("align err_10", SW'(o_err_align), SW'(2'b10));
        check("align ch1_data_8", SW'(dat_reads[1]), SW'(8));

        // Five wait-states on every read
        sts_single(32'h0B, 32'h0B);
        wr_max = 5; wr_rand = 0;
        run_seq("stall");
        check("stall pass_11", SW'(o_pass), SW'(2'b11));
        check("stall snap_w7", SW'(o_snap[255:224]), SW'(7));

        // Randomised statuses, data and stalls
        for (int it = 0; it < 4; it++) begin
            set_addrs();
            for (int c = 0; c < NCH; c++) begin
                int nd = $urandom_range(0, 2);
                logic [31:0] v;
                for (int p = 0; p < nd; p++) begin
                    v = $urandom; v[3] = 1'b0;
                    sts_seq[c][p] = v;
                end
                v = $urandom; v[3] = 1'b1;
                sts_seq[c][nd] = v;
                sts_len[c] = nd + 1;
                for (int w = 0; w < DW; w++) dmem[c][w] = $urandom;
            end
            wr_max = 3; wr_rand = 1;
            run_seq($sformatf("rand%0d", it));
        end

`ifdef AXIST_RDSEQ_TIMEOUT_EN
        // Channel 0 never done: times out after POLL_MAX polls
        set_addrs();
        data_index();
        sts_single(32'h03, 32'h0B);
        wr_max = 0; wr_rand = 0;
        run_seq("tmo");
        check("tmo timeout_01", SW'(o_timeout), SW'(2'b01));
        check("tmo ch0_polls_4", SW'(sts_reads[0]), SW'(4));
        check("tmo ch0_data_0", SW'(dat_reads[0]), SW'(0));
        check("tmo pass_10", SW'(o_pass), SW'(2'b10));
`endif

        // Reset during the third data read, then a fresh run
        set_addrs();
        data_index();
        sts_single(32'h0B, 32'h0B);
        wr_max = 2; wr_rand = 0;
        clear_obs();
        @(negedge avmm_clk) i_start = 1'b1;
        @(negedge avmm_clk) i_start = 1'b0;
        t = 0;
        while (dat_reads[0] < 3 && t < BUDGET) begin
            @(negedge avmm_clk);
            t++;
        end
        check("midrst reached_third", SW'(dat_reads[0] >= 3), SW'(1));
        check("midrst busy_before", SW'(o_busy), SW'(1));
        #2 avmm_rst_n = 1'b0;
        #1 check_all_zero("midrst");
        repeat (2) @(negedge avmm_clk);
        avmm_rst_n = 1'b1;
        stray_valid = 1;
        repeat (4) @(negedge avmm_clk);
        check("midrst idle_busy", SW'(o_busy), SW'(0));
        check("midrst idle_read", SW'(o_read), SW'(0));
        wr_max = 0;
        run_seq("after_rst");
        check("after_rst pass_11", SW'(o_pass), SW'(2'b11));
        check("after_rst snap_w7", SW'(o_snap[255:224]), SW'(7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axist_avmm_rd_seq.md
AXIST_AVMM_RD_SEQ -- requirements
Module: axist_avmm_rd_seq

Interface
REQ-001 SHALL have parameter NUM_CHNL, default 2, number of checker channels polled in order (1..4).
REQ-002 SHALL have parameter DATA_WORDS, default 8, number of 32-bit words per data snapshot (8 = 256 bit).
REQ-003 SHALL have parameter POLL_GAP, default 20, idle avmm_clk cycles between consecutive status polls.
REQ-004 SHALL have parameter POLL_MAX, default 1024, status polls per channel before timeout.
REQ-005 SHALL have port avmm_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port avmm_rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_start  in  1  one-cycle start request.
REQ-008 SHALL have port i_sts_addr  in  32*NUM_CHNL  status register address per channel; channel c at [32c+31:32c].
REQ-009 SHALL have port i_dat_addr  in  32*NUM_CHNL  data snapshot base address per channel.
REQ-010 SHALL have port o_address  out  32  AVMM read address.
REQ-011 SHALL have port o_read  out  1  AVMM read request.
REQ-012 SHALL have port i_waitrequest  in  1  AVMM stall.
REQ-013 SHALL have port i_readdatavalid  in  1  read data qualifier.
REQ-014 SHALL have port i_readdata  in  32  read data.
REQ-015 SHALL have port o_busy  out  1  sequence in progress.
REQ-016 SHALL have port o_done  out  1  one-cycle completion pulse.
REQ-017 SHALL have ports o_pass, o_err_align, o_timeout  out  NUM_CHNL each  per-channel verdict bits.
REQ-018 SHALL have port o_snap  out  32*DATA_WORDS*NUM_CHNL  captured snapshot per channel.

Function
REQ-019 SHALL implement the FSM IDLE -> POLL_RD -> POLL_WAIT -> (GAP -> POLL_RD | DATA_RD) -> DATA_WAIT -> (DATA_RD | NEXT_CH) -> (POLL_RD | DONE) -> IDLE.
REQ-020 SHALL sample i_start only in IDLE, clear all verdicts and snapshots, set channel 0, and enter POLL_RD on the next cycle; i_start in any other state SHALL be ignored.
REQ-021 SHALL hold o_read high with a stable o_address until the first cycle in which i_waitrequest is low; that cycle counts as acceptance.
REQ-022 SHALL keep at most one read outstanding; after acceptance o_read SHALL be low until i_readdatavalid.
REQ-023 Status word: bit3 = done, bit1 = alignment good, bit0 = data match.
REQ-024 In POLL_WAIT on readdatavalid with bit3 = 0: increment poll count and go to GAP for exactly POLL_GAP cycles, then POLL_RD.
REQ-025 On bit3 = 1: set o_pass[c] = bit1 & bit0 and o_err_align[c] = ~bit1, then go to DATA_RD with word index 0.
REQ-026 Data reads SHALL use address i_dat_addr[c] + 4*k for k = 0..DATA_WORDS-1, with word k stored at o_snap bits [c*32*DATA_WORDS + 32k +: 32].
REQ-027 After word DATA_WORDS-1 SHALL go to NEXT_CH: if c = NUM_CHNL-1 go to DONE, else c+1 and POLL_RD.
REQ-028 DONE SHALL last one cycle with o_done = 1 and o_busy = 0; o_busy SHALL be 1 in every other non-IDLE state.
REQ-029 Verdicts and o_snap SHALL hold until the next accepted i_start.
REQ-030 Poll and word counters SHALL be sized to hold POLL_MAX and DATA_WORDS without wrap; the address adder SHALL wrap modulo 2^32.

Reset
REQ-031 On avmm_rst_n low, at any time including mid-read, SHALL force IDLE, clear all counters, and drive o_read = 0, o_address = 0, o_busy = 0, o_done = 0, and o_pass, o_err_align, o_timeout, o_snap = 0.
REQ-032 Any readdatavalid for a read abandoned by reset SHALL be ignored while in IDLE.

Configuration
REQ-033 With AXIST_RDSEQ_TIMEOUT_EN defined: when the poll count reaches POLL_MAX with bit3 still 0, SHALL set o_timeout[c] = 1, leave o_pass[c] = 0, skip the data reads, and go to NEXT_CH.
REQ-034 Without AXIST_RDSEQ_TIMEOUT_EN: SHALL poll indefinitely, with o_timeout tied to 0 and no poll counter implemented.

Verification
REQ-035 NUM_CHNL=2, DATA_WORDS=8, both statuses 0x0B on the first poll, data = word index -> o_pass=2'b11, o_snap[31:0]=0, o_snap[255:224]=7, one o_done pulse.
REQ-036 Channel 0 returns 0x03 three times then 0x0B -> exactly 4 status reads on channel 0, with read issue spacing >= POLL_GAP+2 cycles.
REQ-037 Channel 1 status 0x09 -> o_pass=2'b01, o_err_align=2'b10; data for channel 1 is still read.
REQ-038 i_waitrequest high for 5 cycles on each read -> o_read and o_address stable for 6 cycles; results identical to REQ-035.
REQ-039 With the macro on and POLL_MAX=4, channel 0 never done -> o_timeout=2'b01, 4 status reads, zero data reads on channel 0, channel 1 normal.
REQ-040 Reset asserted during the third data read, then i_start -> all outputs 0 after reset; the fresh sequence completes as in REQ-035.
